eth_tx_arbiter: RTL

//  Shares the single RMII TX path (eth_txd/eth_txen to the LAN8720) between N packet

---
 rtl/eth_tx_arbiter_pkg.sv | 25 ++
 rtl/eth_tx_arbiter_rr_arbiter.sv | 31 +++
 rtl/eth_tx_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/eth_tx_arbiter_pkg.sv
// Shared definitions for the RMII TX arbiter: FSM encoding, default gap length,
// and RMII framing constants also used by the packet generator and receiver.
package eth_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_GAP    = 2'd3
  } tx_state_t;

  localparam int IFG_DIBITS_DEF = 48;
  localparam int GAP_CNT_W      = 6;

  // Preamble is 7 bytes of 0x55 sent LSB first, i.e. 28 dibits of 2'b01;
  // the SFD byte 0xD5 ends with dibit 2'b11.
  localparam int         RMII_PREAMBLE_DIBITS = 28;
  localparam logic [1:0] RMII_PREAMBLE_DIBIT  = 2'b01;
  localparam logic [1:0] RMII_SFD_LAST_DIBIT  = 2'b11;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/eth_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after rr_ptr, wrapping
// from N_SRC-1 back to 0.
module eth_tx_arbiter_rr_arbiter #(
  parameter int N_SRC = 2,
  parameter int PTR_W = 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [PTR_W-1:0] rr_ptr,
  output logic [N_SRC-1:0] pick_onehot,
  output logic [PTR_W-1:0] pick_idx,
  output logic             valid
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    pick_onehot = '0;
    pick_idx    = '0;
    valid       = 1'b0;
    cand        = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % N_SRC);
      if (!valid && req[cand]) begin
        valid             = 1'b1;
        pick_idx          = cand;
        pick_onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Shares the RMII TX pins between N_SRC frame sources: round-robin grant,
// registered dibit forwarding, inter-frame gap, and abort of stuck/runaway sources.
module eth_tx_arbiter
  import eth_tx_arbiter_pkg::*;
#(
  parameter int N_SRC      = 2,
  parameter int IFG_DIBITS = IFG_DIBITS_DEF,
  parameter int START_TO   = 64,
  parameter int MAX_DIBITS = 6144
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               phy_ready,
  input  logic [N_SRC-1:0]   req,
  output logic [N_SRC-1:0]   gnt,
  input  logic [2*N_SRC-1:0] src_txd,
  input  logic [N_SRC-1:0]   src_txen,
  output logic [1:0]         eth_txd,
  output logic               eth_txen,
  output logic               busy,
  output logic               abort
);

  localparam int PTR_W   = ptr_width(N_SRC);
  localparam int LEN_W   = $clog2(MAX_DIBITS + 1);
  localparam int START_W = $clog2(START_TO + 1);

  tx_state_t            state_reg, state_next;
  logic [N_SRC-1:0]     gnt_reg, gnt_next;
  logic [PTR_W-1:0]     g_idx_reg, g_idx_next;
  logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next;
  logic [1:0]           txd_reg, txd_next;
  logic                 txen_reg, txen_next;
  logic                 abort_reg, abort_next;
  logic [GAP_CNT_W-1:0] gap_cnt_reg, gap_cnt_next;
  logic [LEN_W-1:0]     len_cnt_reg, len_cnt_next;
  logic [START_W-1:0]   start_cnt_reg, start_cnt_next;

  logic [N_SRC-1:0] pick_onehot;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_valid;
  logic [PTR_W-1:0] rr_ptr_after;
  logic [1:0]       src_dibit [N_SRC];
  logic             sel_txen;
  logic [1:0]       sel_txd;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_dibit
      assign src_dibit[gi] = src_txd[2*gi +: 2];
    end
  endgenerate

  eth_tx_arbiter_rr_arbiter #(
    .N_SRC (N_SRC),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .req         (req),
    .rr_ptr      (rr_ptr_reg),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .valid       (pick_valid)
  );

  assign sel_txen     = src_txen[g_idx_reg];
  assign sel_txd      = src_dibit[g_idx_reg];
  assign rr_ptr_after = (g_idx_reg == PTR_W'(N_SRC - 1)) ? '0 : g_idx_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    gnt_next       = gnt_reg;
    g_idx_next     = g_idx_reg;
    rr_ptr_next    = rr_ptr_reg;
    txd_next       = 2'b00;
    txen_next      = 1'b0;
    abort_next     = 1'b0;
    gap_cnt_next   = gap_cnt_reg;
    len_cnt_next   = len_cnt_reg;
    start_cnt_next = start_cnt_reg;

    case (state_reg)
      ST_IDLE: begin
        if (phy_ready && pick_valid) begin
          gnt_next       = pick_onehot;
          g_idx_next     = pick_idx;
          start_cnt_next = '0;
          state_next     = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (!phy_ready) begin
          gnt_next    = '0;
          rr_ptr_next = rr_ptr_after;
          state_next  = ST_IDLE;
        end else if (sel_txen) begin
          // First dibit goes out on the same edge that enters ACTIVE.
          txen_next    = 1'b1;
          txd_next     = sel_txd;
          len_cnt_next = '0;
          state_next   = ST_ACTIVE;
        end else if (!req[g_idx_reg]) begin
          gnt_next    = '0;
          rr_ptr_next = rr_ptr_after;
          state_next  = ST_IDLE;
        end else if (start_cnt_reg == START_W'(START_TO - 1)) begin
          abort_next  = 1'b1;
          gnt_next    = '0;
          rr_ptr_next = rr_ptr_after;
          state_next  = ST_IDLE;
        end else if (start_cnt_reg != '1) begin
          start_cnt_next = start_cnt_reg + 1'b1;
        end
      end

      ST_ACTIVE: begin
        // len_cnt_reg+1 dibits are already on the pins; a normal end wins over limits.
        if (!sel_txen) begin
          gnt_next     = '0;
          rr_ptr_next  = rr_ptr_after;
          gap_cnt_next = '0;
          state_next   = ST_GAP;
        end else if (!phy_ready || len_cnt_reg == LEN_W'(MAX_DIBITS - 1)) begin
          abort_next   = 1'b1;
          gnt_next     = '0;
          rr_ptr_next  = rr_ptr_after;
          gap_cnt_next = '0;
          state_next   = ST_GAP;
        end else begin
          txen_next = 1'b1;
          txd_next  = sel_txd;
          if (len_cnt_reg != '1) begin
            len_cnt_next = len_cnt_reg + 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_reg == GAP_CNT_W'(IFG_DIBITS - 1)) begin
          state_next = ST_IDLE;
        end else if (gap_cnt_reg != '1) begin
          gap_cnt_next = gap_cnt_reg + 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      gnt_reg       <= '0;
      g_idx_reg     <= '0;
      rr_ptr_reg    <= '0;
      txd_reg       <= 2'b00;
      txen_reg      <= 1'b0;
      abort_reg     <= 1'b0;
      gap_cnt_reg   <= '0;
      len_cnt_reg   <= '0;
      start_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      gnt_reg       <= gnt_next;
      g_idx_reg     <= g_idx_next;
      rr_ptr_reg    <= rr_ptr_next;
      txd_reg       <= txd_next;
      txen_reg      <= txen_next;
      abort_reg     <= abort_next;
      gap_cnt_reg   <= gap_cnt_next;
      len_cnt_reg   <= len_cnt_next;
      start_cnt_reg <= start_cnt_next;
    end
  end

  assign gnt      = gnt_reg;
  assign eth_txd  = txd_reg;
  assign eth_txen = txen_reg;
  assign abort    = abort_reg;
  assign busy     = (state_reg != ST_IDLE);

endmodule
